// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder/subtractor.
// Stage 1 registers bit-level propagate/generate for the effective operands.
// Stage 2 resolves carries with two-level lookahead (bits within a group,
// groups across the word) and registers sum, carry-out and overflow.
// Valid/ready handshakes on both sides; at most two beats are held.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  // Reject illegal geometries at elaboration time.
  if (GROUP < 1) begin : g_bad_group
    $error("cla_pipe_adder: GROUP must be at least 1");
  end else if (WIDTH % GROUP != 0) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end

  localparam int NG = (GROUP < 1) ? 1 : WIDTH / GROUP;

  // ---------------------------------------------------------------
  // Flow control
  // ---------------------------------------------------------------
  logic s1_valid;
  logic s2_adv;
  logic s1_adv;
  logic in_fire;

  // Stage 2 may load whenever its slot is empty or is being drained.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  // Depends only on pipeline state and out_ready, never on in_valid.
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;

  // ---------------------------------------------------------------
  // Stage 1: operand conditioning and bit-level propagate/generate
  // ---------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             c0_in;
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] g_reg;
  logic             c0_reg;
  logic             sa_reg;
  logic             sb_reg;

  // Subtraction is A + ~B + 1, so the carry-in is forced high.
  assign b_eff = sub ? ~b : b;
  assign c0_in = sub | c_in;

  // Capture a new beat, or empty stage 1 when its beat moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      p_reg    <= '0;
      g_reg    <= '0;
      c0_reg   <= 1'b0;
      sa_reg   <= 1'b0;
      sb_reg   <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      p_reg    <= a ^ b_eff;
      g_reg    <= a & b_eff;
      c0_reg   <= c0_in;
      sa_reg   <= a[WIDTH-1];
      sb_reg   <= b_eff[WIDTH-1];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // ---------------------------------------------------------------
  // Stage 2 combinational carry resolution
  // ---------------------------------------------------------------
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [NG:0]      grp_c;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_next;
  logic             ovf_next;

  assign grp_c[0] = c0_reg;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      // Group generate: carry out of the group assuming zero carry in.
      logic [GROUP:0] gen_chain;
      assign gen_chain[0] = 1'b0;
      for (gj = 0; gj < GROUP; gj++) begin : g_gen
        assign gen_chain[gj+1] = g_reg[gi*GROUP+gj]
                               | (p_reg[gi*GROUP+gj] & gen_chain[gj]);
      end
      assign grp_g[gi] = gen_chain[GROUP];
      assign grp_p[gi] = &p_reg[gi*GROUP +: GROUP];

      // Group-level lookahead across the word.
      assign grp_c[gi+1] = grp_g[gi] | (grp_p[gi] & grp_c[gi]);

      // Bit carries inside the group start from the resolved group carry.
      assign c[gi*GROUP] = grp_c[gi];
      for (gj = 0; gj < GROUP - 1; gj++) begin : g_bit
        assign c[gi*GROUP+gj+1] = g_reg[gi*GROUP+gj]
                                | (p_reg[gi*GROUP+gj] & c[gi*GROUP+gj]);
      end
    end
  endgenerate

  assign c[WIDTH]  = grp_c[NG];
  assign sum_next  = p_reg ^ c[WIDTH-1:0];
  // Same-sign operands producing an opposite-sign result; equivalent to
  // c[WIDTH] ^ c[WIDTH-1], but taken from the registered operand signs.
  assign ovf_next  = (sa_reg == sb_reg) && (sum_next[WIDTH-1] != sa_reg);

  // ---------------------------------------------------------------
  // Stage 2 register: results hold while the consumer stalls.
  // ---------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum   <= sum_next;
        c_out <= c[WIDTH];
        ovf   <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: randomized and directed checks of cla_pipe_adder
// (WIDTH=16, GROUP=4) against an arithmetic reference model.
module tb_cla_pipe_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  res_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   out_cnt = 0;
  int   last_out_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact unsigned and signed arithmetic, reduced afterwards.
  function automatic res_t model(input logic [W-1:0] ua, input logic [W-1:0] ub,
                                 input logic cin, input logic sb);
    res_t   r;
    longint full, sa, sbv, sr;
    sa  = longint'(ua) - (ua[W-1] ? 65536 : 0);
    sbv = longint'(ub) - (ub[W-1] ? 65536 : 0);
    if (sb) begin
      full = longint'(ua) - longint'(ub);
      r.c  = (ua >= ub);
      sr   = sa - sbv;
    end else begin
      full = longint'(ua) + longint'(ub) + longint'(cin);
      r.c  = (full >= 65536);
      sr   = sa + sbv + longint'(cin);
    end
    r.s = full[W-1:0];
    r.v = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Compare process: sampled on the falling edge, between active edges.
  logic         hold_prev = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_c, hold_v;
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_sum", sum, hold_sum);
        chk("stall_cout", c_out, hold_c);
        chk("stall_ovf", ovf, hold_v);
      end
      if (in_valid && in_ready) q.push_back(model(a, b, c_in, sub));
      if (out_valid) begin
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out: sum=%0h with no beat outstanding", sum);
        end else begin
          e = q[0];
          chk("model_sum", sum, e.s);
          chk("model_cout", c_out, e.c);
          chk("model_ovf", ovf, e.v);
          if (out_ready) begin
            void'(q.pop_front());
            out_cnt++;
            last_out_edge = cyc + 1;
            $display("out #%0d sum=%h c_out=%b ovf=%b", out_cnt, sum, c_out, ovf);
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_sum  = sum;
      hold_c    = c_out;
      hold_v    = ovf;
    end
  end

  // Present one beat and hold it until accepted; returns #1 after the transfer edge.
  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic vc, input logic vs);
    logic fired;
    a = va; b = vb; c_in = vc; sub = vs; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); fired = in_ready;
      @(posedge clk); #1;
      if (fired) begin
        in_valid = 1'b0;
        return;
      end
    end
    n_vec++; n_err++;
    $display("FAIL send_timeout: in_ready stayed 0, required 1");
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for the next result and pin it to literal values.
  task automatic expect_lit(input string name, input logic [W-1:0] es,
                            input logic ec, input logic ev);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        chk({name, "_sum"}, sum, es);
        chk({name, "_cout"}, c_out, ec);
        chk({name, "_ovf"}, ovf, ev);
        @(posedge clk); #1;
        return;
      end
    end
    n_vec++; n_err++;
    $display("FAIL %s_timeout: out_valid stayed 0, required 1", name);
  endtask

  task automatic drain;
    int k;
    k = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk); #1; k++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    int acc, start, base;
    logic fired;

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Ripple across every group, latency of two edges
    a = 16'hFFFF; b = 16'h0000; c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk); chk("lat_in_ready", in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("lat_edge1_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", out_valid, 1);
    chk("ripple_sum", sum, 16'h0000);
    chk("ripple_cout", c_out, 1);
    chk("ripple_ovf", ovf, 0);
    @(posedge clk); #1;

    // Subtraction with overflow, then a borrow
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    expect_lit("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
    send(16'h0003, 16'h0005, 1'b1, 1'b1);
    expect_lit("sub_borrow", 16'hFFFE, 1'b0, 1'b0);

    // Backpressure: 5 stalled cycles, only two beats fit
    out_ready = 1'b0; acc = 0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); fired = in_ready;
      @(posedge clk); #1;
      if (fired) begin
        acc++;
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      end
    end
    chk("bp_accepted", acc, 2);
    @(negedge clk); chk("bp_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && acc < 8; k++) begin
      @(negedge clk); fired = in_ready;
      @(posedge clk); #1;
      if (fired) begin
        acc++;
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("bp_total", acc, 8);
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    send(16'h4321, 16'h0101, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("post_rst_valid", out_valid, 0);
    end
    @(posedge clk); #1;

    // Throughput: 100 back-to-back beats
    base = out_cnt;
    start = cyc + 1;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
      @(negedge clk); chk("tp_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 20 && out_cnt < base + 100; k++) begin
      @(posedge clk); #1;
    end
    chk("tp_results", out_cnt - base, 100);
    chk("tp_cycles", last_out_edge - start, 101);

    // Random traffic with random stalls
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); fired = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || fired) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
        if ($urandom_range(0, 7) == 0) a = 16'h8000;
        if ($urandom_range(0, 7) == 0) b = 16'hFFFF;
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk); fired = in_valid && in_ready;
    @(posedge clk); #1;
    if (!fired) begin
      @(negedge clk); fired = in_valid && in_ready;
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
